// File: rtl/complex_pkg.sv
// Shared types and constants for the complex (mul/div) issue path.
package complex_pkg;

    localparam int TAG_W = 6;
    localparam int ROB_W = 5;

    // bit2 selects divide, bits1:0 the variant
    localparam logic [2:0] CX_MUL    = 3'b000;
    localparam logic [2:0] CX_MULH   = 3'b001;
    localparam logic [2:0] CX_MULHSU = 3'b010;
    localparam logic [2:0] CX_MULHU  = 3'b011;
    localparam logic [2:0] CX_DIV    = 3'b100;
    localparam logic [2:0] CX_DIVU   = 3'b101;
    localparam logic [2:0] CX_REM    = 3'b110;
    localparam logic [2:0] CX_REMU   = 3'b111;

    typedef struct packed {
        logic [2:0]       opcode;
        logic [TAG_W-1:0] src1;
        logic [TAG_W-1:0] src2;
        logic             rdy1;
        logic             rdy2;
        logic [TAG_W-1:0] dest;
        logic [ROB_W-1:0] rob;
    } ciq_entry_t;

endpackage

// File: rtl/tag_match.sv
// Compares one source tag against every valid writeback broadcast.
module tag_match #(
    parameter int TAG_W = 6,
    parameter int NPORT = 2
) (
    input  logic [TAG_W-1:0]       tag,
    input  logic [NPORT-1:0]       bc_valid,
    input  logic [NPORT*TAG_W-1:0] bc_tag,
    output logic                   hit
);

    always_comb begin
        hit = 1'b0;
        for (int k = 0; k < NPORT; k++) begin
            if (bc_valid[k] && (bc_tag[k*TAG_W +: TAG_W] == tag))
                hit = 1'b1;
        end
    end

endmodule

// File: rtl/complex_issue_queue.sv
// In-order issue queue feeding the complex unit; issues the head once both
// sources are ready (with same-cycle wakeup bypass) and the unit is free.
module complex_issue_queue #(
    parameter int DEPTH = 4,
    parameter int TAG_W = complex_pkg::TAG_W,
    parameter int ROB_W = complex_pkg::ROB_W
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               flush_i,
    input  logic               dispatch_valid_i,
    output logic               dispatch_ready_o,
    input  logic [2:0]         dispatch_opcode_i,
    input  logic [TAG_W-1:0]   dispatch_src1_i,
    input  logic [TAG_W-1:0]   dispatch_src2_i,
    input  logic               dispatch_src1_rdy_i,
    input  logic               dispatch_src2_rdy_i,
    input  logic [TAG_W-1:0]   dispatch_dest_i,
    input  logic [ROB_W-1:0]   dispatch_rob_i,
    input  logic [1:0]         wakeup_valid_i,
    input  logic [2*TAG_W-1:0] wakeup_tag_i,
    input  logic               unit_busy_i,
    output logic               issue_valid_o,
    output logic [2:0]         issue_opcode_o,
    output logic [TAG_W-1:0]   issue_src1_o,
    output logic [TAG_W-1:0]   issue_src2_o,
    output logic [TAG_W-1:0]   issue_dest_o,
    output logic [ROB_W-1:0]   issue_rob_o
);
    import complex_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int NWAKE = 2;

    ciq_entry_t       q_mem [DEPTH];
    logic [PTR_W-1:0] head_q, tail_q;
    logic [PTR_W:0]   count_q;
    logic [DEPTH-1:0] occ, hit1, hit2;
    logic             d_hit1, d_hit2;
    logic             enq, issue_go, head_ok;
    ciq_entry_t       head_e, new_e;

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        logic [PTR_W-1:0] off;

        tag_match #(.TAG_W(TAG_W), .NPORT(NWAKE)) u_m1 (
            .tag(q_mem[i].src1), .bc_valid(wakeup_valid_i), .bc_tag(wakeup_tag_i), .hit(hit1[i])
        );
        tag_match #(.TAG_W(TAG_W), .NPORT(NWAKE)) u_m2 (
            .tag(q_mem[i].src2), .bc_valid(wakeup_valid_i), .bc_tag(wakeup_tag_i), .hit(hit2[i])
        );

        // distance from head decides whether slot i holds a live op
        assign off    = PTR_W'(i) - head_q;
        assign occ[i] = ({1'b0, off} < count_q);
    end

    tag_match #(.TAG_W(TAG_W), .NPORT(NWAKE)) u_d1 (
        .tag(dispatch_src1_i), .bc_valid(wakeup_valid_i), .bc_tag(wakeup_tag_i), .hit(d_hit1)
    );
    tag_match #(.TAG_W(TAG_W), .NPORT(NWAKE)) u_d2 (
        .tag(dispatch_src2_i), .bc_valid(wakeup_valid_i), .bc_tag(wakeup_tag_i), .hit(d_hit2)
    );

    assign dispatch_ready_o = (count_q != (PTR_W+1)'(DEPTH));
    assign enq              = dispatch_valid_i && dispatch_ready_o && !flush_i;

    assign head_e  = q_mem[head_q];
    assign head_ok = (head_e.rdy1 | hit1[head_q]) & (head_e.rdy2 | hit2[head_q]);
    // the issue_valid_o term forces an idle cycle while the unit raises busy
    assign issue_go = (count_q != '0) && head_ok && !unit_busy_i && !issue_valid_o && !flush_i;

    assign new_e = '{opcode: dispatch_opcode_i,
                     src1:   dispatch_src1_i,
                     src2:   dispatch_src2_i,
                     rdy1:   dispatch_src1_rdy_i | d_hit1,
                     rdy2:   dispatch_src2_rdy_i | d_hit2,
                     dest:   dispatch_dest_i,
                     rob:    dispatch_rob_i};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (enq)      tail_q <= tail_q + 1'b1;
            if (issue_go) head_q <= head_q + 1'b1;
            case ({enq, issue_go})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // payload storage carries no reset; free slots are rewritten on enqueue
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (occ[i] && hit1[i]) q_mem[i].rdy1 <= 1'b1;
            if (occ[i] && hit2[i]) q_mem[i].rdy2 <= 1'b1;
        end
        if (enq) q_mem[tail_q] <= new_e;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            issue_valid_o  <= 1'b0;
            issue_opcode_o <= '0;
            issue_src1_o   <= '0;
            issue_src2_o   <= '0;
            issue_dest_o   <= '0;
            issue_rob_o    <= '0;
        end else begin
            issue_valid_o <= issue_go;
            if (issue_go) begin
                issue_opcode_o <= head_e.opcode;
                issue_src1_o   <= head_e.src1;
                issue_src2_o   <= head_e.src2;
                issue_dest_o   <= head_e.dest;
                issue_rob_o    <= head_e.rob;
            end
        end
    end

endmodule

// File: tb/tb_complex_issue_queue.sv
// Bench for complex_issue_queue: directed table, corner sequences and a
// randomized run against a queue-based reference model.
module tb_complex_issue_queue;
    import complex_pkg::*;

    localparam int DEPTH = 4;

    logic        clk_i = 1'b0;
    logic        rst_ni, flush_i, dispatch_valid_i, dispatch_ready_o;
    logic [2:0]  dispatch_opcode_i;
    logic [5:0]  dispatch_src1_i, dispatch_src2_i, dispatch_dest_i;
    logic        dispatch_src1_rdy_i, dispatch_src2_rdy_i;
    logic [4:0]  dispatch_rob_i;
    logic [1:0]  wakeup_valid_i;
    logic [11:0] wakeup_tag_i;
    logic        unit_busy_i, issue_valid_o;
    logic [2:0]  issue_opcode_o;
    logic [5:0]  issue_src1_o, issue_src2_o, issue_dest_o;
    logic [4:0]  issue_rob_o;

    always #5 clk_i = ~clk_i;

    complex_issue_queue #(.DEPTH(DEPTH), .TAG_W(6), .ROB_W(5)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .dispatch_valid_i(dispatch_valid_i), .dispatch_ready_o(dispatch_ready_o),
        .dispatch_opcode_i(dispatch_opcode_i),
        .dispatch_src1_i(dispatch_src1_i), .dispatch_src2_i(dispatch_src2_i),
        .dispatch_src1_rdy_i(dispatch_src1_rdy_i), .dispatch_src2_rdy_i(dispatch_src2_rdy_i),
        .dispatch_dest_i(dispatch_dest_i), .dispatch_rob_i(dispatch_rob_i),
        .wakeup_valid_i(wakeup_valid_i), .wakeup_tag_i(wakeup_tag_i),
        .unit_busy_i(unit_busy_i), .issue_valid_o(issue_valid_o),
        .issue_opcode_o(issue_opcode_o), .issue_src1_o(issue_src1_o),
        .issue_src2_o(issue_src2_o), .issue_dest_o(issue_dest_o), .issue_rob_o(issue_rob_o)
    );

    typedef struct packed {
        logic [2:0] op;
        logic [5:0] s1, s2;
        logic       r1, r2;
        logic [5:0] dest;
        logic [4:0] rob;
    } mop_t;

    typedef struct {
        bit dv; logic [2:0] op; logic [5:0] s1, s2; bit r1, r2;
        logic [5:0] dest; logic [4:0] rob; logic [1:0] wv; logic [5:0] w0, w1;
        bit exp_iv; logic [5:0] exp_dest; logic [4:0] exp_rob;
    } vec_t;

    mop_t mq[$];
    bit   exp_iv;
    mop_t exp_out;
    int   checks = 0, failures = 0;
    vec_t tbl[20];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit woken(logic [5:0] t);
        return (wakeup_valid_i[0] && wakeup_tag_i[5:0] == t) ||
               (wakeup_valid_i[1] && wakeup_tag_i[11:6] == t);
    endfunction

    task automatic drive(bit dv, logic [2:0] op, logic [5:0] s1, logic [5:0] s2, bit r1, bit r2,
                         logic [5:0] dest, logic [4:0] rob, logic [1:0] wv, logic [5:0] w0,
                         logic [5:0] w1, bit busy, bit fl);
        dispatch_valid_i = dv;  dispatch_opcode_i = op;
        dispatch_src1_i = s1;   dispatch_src2_i = s2;
        dispatch_src1_rdy_i = r1; dispatch_src2_rdy_i = r2;
        dispatch_dest_i = dest; dispatch_rob_i = rob;
        wakeup_valid_i = wv;    wakeup_tag_i = {w1, w0};
        unit_busy_i = busy;     flush_i = fl;
    endtask

    // model the edge from the queue's rules, then compare after it
    task automatic step();
        bit rdy, elig;
        mop_t m;
        #1;
        rdy = (mq.size() != DEPTH);
        chk("dispatch_ready", dispatch_ready_o, rdy);
        if (flush_i) begin
            mq.delete();
            exp_iv = 1'b0;
        end else begin
            elig = mq.size() > 0 && (mq[0].r1 || woken(mq[0].s1)) &&
                   (mq[0].r2 || woken(mq[0].s2)) && !unit_busy_i && !exp_iv;
            foreach (mq[i]) begin
                if (woken(mq[i].s1)) mq[i].r1 = 1'b1;
                if (woken(mq[i].s2)) mq[i].r2 = 1'b1;
            end
            if (elig) exp_out = mq.pop_front();
            if (dispatch_valid_i && rdy) begin
                m.op = dispatch_opcode_i; m.s1 = dispatch_src1_i; m.s2 = dispatch_src2_i;
                m.r1 = dispatch_src1_rdy_i || woken(dispatch_src1_i);
                m.r2 = dispatch_src2_rdy_i || woken(dispatch_src2_i);
                m.dest = dispatch_dest_i; m.rob = dispatch_rob_i;
                mq.push_back(m);
            end
            exp_iv = elig;
        end
        @(posedge clk_i); #1;
        chk("issue_valid", issue_valid_o, exp_iv);
        chk("issue_opcode", issue_opcode_o, exp_out.op);
        chk("issue_src1", issue_src1_o, exp_out.s1);
        chk("issue_src2", issue_src2_o, exp_out.s2);
        chk("issue_dest", issue_dest_o, exp_out.dest);
        chk("issue_rob", issue_rob_o, exp_out.rob);
    endtask

    task automatic cycle(bit dv, logic [2:0] op, logic [5:0] s1, logic [5:0] s2, bit r1, bit r2,
                         logic [5:0] dest, logic [4:0] rob, logic [1:0] wv, logic [5:0] w0,
                         logic [5:0] w1, bit busy, bit fl);
        @(negedge clk_i);
        drive(dv, op, s1, s2, r1, r2, dest, rob, wv, w0, w1, busy, fl);
        step();
    endtask

    task automatic idle(bit busy);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, busy, 0);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_ni = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        #1;
        chk("rst_issue_valid", issue_valid_o, 0);
        chk("rst_issue_data", {issue_opcode_o, issue_src1_o, issue_src2_o, issue_dest_o, issue_rob_o}, 0);
        chk("rst_dispatch_ready", dispatch_ready_o, 1);
        mq.delete();
        exp_iv = 1'b0;
        exp_out = '0;
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    function automatic vec_t mk(bit dv, logic [2:0] op, logic [5:0] s1, logic [5:0] s2, bit r1, bit r2,
                                logic [5:0] dest, logic [4:0] rob, logic [1:0] wv, logic [5:0] w0,
                                logic [5:0] w1, bit eiv, logic [5:0] ed, logic [4:0] er);
        vec_t v;
        v.dv = dv; v.op = op; v.s1 = s1; v.s2 = s2; v.r1 = r1; v.r2 = r2; v.dest = dest;
        v.rob = rob; v.wv = wv; v.w0 = w0; v.w1 = w1; v.exp_iv = eiv; v.exp_dest = ed; v.exp_rob = er;
        return v;
    endfunction

    initial begin
        logic [5:0] got[$];
        bit prev_iv;

        rst_ni = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);

        // basic issue, wakeup bypass, dispatch-cycle wakeup, head-of-line blocking
        tbl[0]  = mk(1, CX_MUL,  5,  6, 1, 1,  9, 3, 2'b00,  0,  0, 0,  0, 0);
        tbl[1]  = mk(0, 0,       0,  0, 0, 0,  0, 0, 2'b00,  0,  0, 1,  9, 3);
        tbl[2]  = mk(0, 0,       0,  0, 0, 0,  0, 0, 2'b00,  0,  0, 0,  0, 0);
        tbl[3]  = mk(1, CX_DIV, 12,  7, 0, 1, 20, 4, 2'b00,  0,  0, 0,  0, 0);
        tbl[4]  = mk(0, 0,       0,  0, 0, 0,  0, 0, 2'b00,  0,  0, 0,  0, 0);
        tbl[5]  = mk(0, 0,       0,  0, 0, 0,  0, 0, 2'b00,  0,  0, 0,  0, 0);
        tbl[6]  = mk(0, 0,       0,  0, 0, 0,  0, 0, 2'b00,  0,  0, 0,  0, 0);
        tbl[7]  = mk(0, 0,       0,  0, 0, 0,  0, 0, 2'b00,  0,  0, 0,  0, 0);
        tbl[8]  = mk(0, 0,       0,  0, 0, 0,  0, 0, 2'b10,  0, 12, 1, 20, 4);
        tbl[9]  = mk(0, 0,       0,  0, 0, 0,  0, 0, 2'b00,  0,  0, 0,  0, 0);
        tbl[10] = mk(1, CX_MUL,  3, 33, 1, 0, 11, 5, 2'b01, 33,  0, 0,  0, 0);
        tbl[11] = mk(0, 0,       0,  0, 0, 0,  0, 0, 2'b00,  0,  0, 1, 11, 5);
        tbl[12] = mk(0, 0,       0,  0, 0, 0,  0, 0, 2'b00,  0,  0, 0,  0, 0);
        tbl[13] = mk(1, CX_DIVU,40,  1, 0, 1, 12, 6, 2'b00,  0,  0, 0,  0, 0);
        tbl[14] = mk(1, CX_MULH, 2,  3, 1, 1, 13, 7, 2'b00,  0,  0, 0,  0, 0);
        tbl[15] = mk(0, 0,       0,  0, 0, 0,  0, 0, 2'b00,  0,  0, 0,  0, 0);
        tbl[16] = mk(0, 0,       0,  0, 0, 0,  0, 0, 2'b01, 40,  0, 1, 12, 6);
        tbl[17] = mk(0, 0,       0,  0, 0, 0,  0, 0, 2'b00,  0,  0, 0,  0, 0);
        tbl[18] = mk(0, 0,       0,  0, 0, 0,  0, 0, 2'b00,  0,  0, 1, 13, 7);
        tbl[19] = mk(0, 0,       0,  0, 0, 0,  0, 0, 2'b00,  0,  0, 0,  0, 0);

        do_reset();
        for (int i = 0; i < 20; i++) begin
            cycle(tbl[i].dv, tbl[i].op, tbl[i].s1, tbl[i].s2, tbl[i].r1, tbl[i].r2, tbl[i].dest,
                  tbl[i].rob, tbl[i].wv, tbl[i].w0, tbl[i].w1, 0, 0);
            chk($sformatf("tbl%0d_iv", i), issue_valid_o, tbl[i].exp_iv);
            if (tbl[i].exp_iv) begin
                chk($sformatf("tbl%0d_dest", i), issue_dest_o, tbl[i].exp_dest);
                chk($sformatf("tbl%0d_rob", i), issue_rob_o, tbl[i].exp_rob);
            end
        end

        // fill while busy, drain in order with gaps, then wrap the tail
        do_reset();
        for (int i = 0; i < 4; i++)
            cycle(1, CX_MUL, 6'(i), 6'(i + 1), 1, 1, 6'(20 + i), 5'(10 + i), 2'b00, 0, 0, 1, 0);
        chk("full_ready", dispatch_ready_o, 0);
        cycle(1, CX_REM, 1, 1, 1, 1, 50, 1, 2'b00, 0, 0, 1, 0);
        prev_iv = 1'b0;
        for (int i = 0; i < 12; i++) begin
            idle(0);
            if (issue_valid_o) begin
                got.push_back(issue_dest_o);
                checks++;
                if (prev_iv) begin
                    failures++;
                    $display("FAIL back_to_back: issue on consecutive cycles at drain cycle %0d", i);
                end
            end
            prev_iv = issue_valid_o;
        end
        chk("drain_count", got.size(), 4);
        for (int k = 0; k < got.size(); k++) chk($sformatf("drain_order%0d", k), got[k], 20 + k);
        cycle(1, CX_REMU, 8, 9, 1, 1, 30, 2, 2'b00, 0, 0, 0, 0);
        idle(0);
        chk("wrap_issue", issue_valid_o, 1);
        chk("wrap_dest", issue_dest_o, 30);

        // flush with concurrent dispatch discards everything
        do_reset();
        for (int i = 0; i < 3; i++)
            cycle(1, CX_DIV, 6'(i), 6'(i), 1, 1, 6'(40 + i), 5'(i), 2'b00, 0, 0, 1, 0);
        cycle(1, CX_MUL, 1, 2, 1, 1, 45, 9, 2'b11, 1, 2, 0, 1);
        chk("flush_iv", issue_valid_o, 0);
        chk("flush_ready", dispatch_ready_o, 1);
        for (int i = 0; i < 3; i++) begin
            idle(0);
            chk("post_flush_iv", issue_valid_o, 0);
        end

        // asynchronous reset while the issue pulse is high
        cycle(1, CX_MULHU, 4, 5, 1, 1, 17, 8, 2'b00, 0, 0, 0, 0);
        idle(0);
        chk("pre_rst_iv", issue_valid_o, 1);
        #2 rst_ni = 1'b0;
        #1;
        chk("async_rst_iv", issue_valid_o, 0);
        chk("async_rst_dest", issue_dest_o, 0);

        // randomized traffic against the reference model
        do_reset();
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)),
                  6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)),
                  $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                  6'($urandom_range(0, 63)), 5'($urandom_range(0, 31)),
                  2'($urandom_range(0, 3)), 6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)),
                  $urandom_range(0, 3) == 0, $urandom_range(0, 31) == 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/complex_issue_queue.md
Name: complex_issue_queue

Overview:
- In-order issue queue directly upstream of the complex (mul/div) unit.
- Accepts renamed multiply/divide ops from dispatch and tracks source-operand readiness through writeback tag broadcasts.
- Issues the oldest op only when both of its sources are ready and the complex unit is not busy.
- Issued ops go to register read, which then drives the complex unit's opcode, operands and valid.

Parameters:
- DEPTH, 4, number of queue entries (power of two, ≥2).
- TAG_W, 6, physical register tag width.
- ROB_W, 5, reorder-buffer index width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- flush_i  in  1  pipeline flush; empties the queue.
- dispatch_valid_i  in  1  dispatch offers an op.
- dispatch_ready_o  out  1  queue can accept an op this cycle.
- dispatch_opcode_i  in  3  complex opcode: bit2 = divide, bits1:0 = variant.
- dispatch_src1_i / dispatch_src2_i  in  TAG_W each  source tags.
- dispatch_src1_rdy_i / dispatch_src2_rdy_i  in  1 each  source already available at dispatch.
- dispatch_dest_i  in  TAG_W  destination tag.
- dispatch_rob_i  in  ROB_W  ROB index.
- wakeup_valid_i  in  2  writeback broadcast valids (ALU port and complex port).
- wakeup_tag_i  in  2*TAG_W  broadcast tags; port k occupies bits [k*TAG_W +: TAG_W].
- unit_busy_i  in  1  complex unit busy (its busy output).
- issue_valid_o  out  1  registered single-cycle issue pulse.
- issue_opcode_o  out  3  issued opcode.
- issue_src1_o / issue_src2_o  out  TAG_W each  issued source tags.
- issue_dest_o  out  TAG_W  issued destination tag.
- issue_rob_o  out  ROB_W  issued ROB index.

Behaviour:
- Storage: circular buffer with head/tail pointers of clog2(DEPTH) bits plus a count of clog2(DEPTH)+1 bits.
  - Each entry holds: opcode, src1 tag, src2 tag, rdy1, rdy2, dest tag, ROB index.
- Reset (rst_ni low, async): pointers 0, count 0, issue_valid_o 0. All issue_* data outputs 0.
- dispatch_ready_o = (count != DEPTH).
  - A dequeue in the same cycle does not relax this; a full queue stalls dispatch for one cycle.
- Enqueue on dispatch_valid_i && dispatch_ready_o: write the entry at tail, tail++ (wraps modulo DEPTH).
  - Stored rdyN = dispatch_srcN_rdy_i OR (any wakeup_valid_i[k] with wakeup_tag_i[k] == dispatch_srcN_i).
- Wakeup: every cycle, any valid entry whose srcN matches a valid broadcast tag sets rdyN at the clock edge.
  - rdyN, once set, never clears until the entry is freed.
- Issue eligibility, evaluated combinationally:
  - count != 0, and
  - head rdy1 is set or matches a wakeup this cycle (same-cycle bypass), and
  - the same holds for head rdy2, and
  - !unit_busy_i and !issue_valid_o and !flush_i.
- On eligibility at the clock edge:
  - issue_valid_o <= 1 and issue_* <= head fields.
  - head++ (wraps), count--.
- Otherwise issue_valid_o <= 0; issue_* data holds its previous value.
- Blocking on issue_valid_o guarantees at least one idle cycle between issues. This covers the cycle in which the complex unit has not yet registered busy.
- Strict in-order: a non-ready head blocks younger ready entries.
- Simultaneous enqueue and issue: count unchanged, both pointers advance.
- Enqueue into an empty queue with both sources ready: issue at the earliest on the following edge.
  - There is no dispatch-to-issue bypass; minimum latency is 1 cycle from enqueue to issue_valid_o.
- flush_i (synchronous, priority over everything except reset):
  - Next edge: count 0, head = tail = 0, issue_valid_o 0.
  - Dispatch and wakeups in the flush cycle are discarded.
- Wakeups never touch free entries, so a free entry's ready bits are don't-care. Enqueue overwrites them.

Decomposition:
- Shared package complex_pkg:
  - typedef ciq_entry_t (packed struct of the entry fields).
  - Opcode constants: CX_MUL, CX_MULH, CX_MULHSU, CX_MULHU, CX_DIV, CX_DIVU, CX_REM, CX_REMU.
  - Parameters TAG_W and ROB_W.
- Sub-module tag_match: compares one tag against the broadcast vector and returns a hit. It is instantiated per entry per source and for the dispatch inputs.

Test Plan:
- Reset, then dispatch MUL with src 5 and 6 both ready, dest 9, rob 3 → issue_valid_o pulses exactly one cycle later with issue_dest_o = 9, issue_rob_o = 3; count returns to 0.
- Dispatch DIV with src1 = 12 not ready; hold 4 cycles; broadcast wakeup port 1 tag 12 → issue_valid_o in the same-edge cycle (bypass); no issue before that.
- Fill 4 ops with unit_busy_i = 1 → dispatch_ready_o = 0 after the 4th. Release busy → ops issue in order, never on consecutive cycles; tail wraps to 0 and a 5th op is accepted.
- Head not ready, entry 1 ready → nothing issues until the head wakes; then head issues, followed by entry 1 at least 2 cycles later.
- Wakeup tag equal to dispatch_src2_i in the dispatch cycle → entry stored ready, issued next cycle.
- Queue holding 3 ops: assert flush_i together with dispatch_valid_i → next cycle count = 0, issue_valid_o = 0, dispatch_ready_o = 1. Assert rst_ni low mid-issue → issue_valid_o drops immediately.
